// File: rtl/proj_accum_pkg.sv
// Shared types, default widths and the saturating/wrapping adder for the
// eigenface projection accumulator bank.
package proj_accum_pkg;

  localparam int DEF_NUM_WEIGHTS = 240;
  localparam int DEF_LANES       = 8;
  localparam int DEF_PIX_W       = 9;
  localparam int DEF_P_W         = 8;
  localparam int DEF_ACC_W       = 32;
  localparam int SAT_W           = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic signed [SAT_W-1:0] sum;
    logic                    ovf;
  } sat_res_t;

  // Adds in a 64-bit domain, then either clamps to the acc_w-bit signed range
  // or folds the result back into it; ovf flags either case.
  function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] acc,
                                       input logic signed [SAT_W-1:0] prod,
                                       input int                      acc_w,
                                       input logic                    sat_en);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    logic signed [SAT_W-1:0] sum;
    logic signed [SAT_W-1:0] wrapped;
    int                      sh;
    sat_res_t                res;
    sh      = SAT_W - acc_w;
    hi      = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    lo      = -hi - 64'sd1;
    sum     = acc + prod;
    wrapped = (sum <<< sh) >>> sh;
    res.sum = sum;
    res.ovf = 1'b0;
    if (sum > hi) begin
      res.ovf = 1'b1;
      res.sum = sat_en ? hi : wrapped;
    end else if (sum < lo) begin
      res.ovf = 1'b1;
      res.sum = sat_en ? lo : wrapped;
    end
    return res;
  endfunction

endpackage

// File: rtl/proj_lane_mac.sv
// One lane: (f - m) * p product register followed by the combinational
// saturating accumulate that the bank commits on the next edge.
module proj_lane_mac
  import proj_accum_pkg::*;
#(
  parameter int PIX_W  = DEF_PIX_W,
  parameter int P_W    = DEF_P_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int SAT_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             beat,
  input  logic [PIX_W-1:0] f,
  input  logic [PIX_W-1:0] m,
  input  logic [P_W-1:0]   p,
  input  logic [ACC_W-1:0] acc_cur,
  output logic             prod_valid,
  output logic [ACC_W-1:0] acc_next,
  output logic             acc_ovf
);

  localparam int PROD_W = PIX_W + P_W + 1;

  logic signed [PIX_W:0]    diff;
  logic signed [PROD_W:0]   prod_full;
  logic signed [PROD_W-1:0] prod_q;
  sat_res_t                 res;

  // p is unsigned, so |p * d| < 2^(PROD_W-1) and the top bit of prod_full is
  // only a sign copy.
  always_comb begin
    diff      = $signed({1'b0, f}) - $signed({1'b0, m});
    prod_full = (PROD_W + 1)'($signed({1'b0, p})) * (PROD_W + 1)'(diff);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q     <= '0;
      prod_valid <= 1'b0;
    end else begin
      prod_valid <= beat;
      if (beat) prod_q <= prod_full[PROD_W-1:0];
    end
  end

  always_comb begin
    res      = sat_add(SAT_W'($signed(acc_cur)), SAT_W'(prod_q), ACC_W, SAT_EN != 0);
    acc_next = res.sum[ACC_W-1:0];
    acc_ovf  = prod_valid & res.ovf;
  end

endmodule

// File: rtl/proj_accum_bank.sv
// Streaming projection accumulator: pass FSM, LANES parallel MAC lanes, a
// NUM_WEIGHTS-deep signed accumulator bank and a registered random readout.
module proj_accum_bank
  import proj_accum_pkg::*;
#(
  parameter  int NUM_WEIGHTS = DEF_NUM_WEIGHTS,
  parameter  int LANES       = DEF_LANES,
  parameter  int PIX_W       = DEF_PIX_W,
  parameter  int P_W         = DEF_P_W,
  parameter  int ACC_W       = DEF_ACC_W,
  parameter  int SAT_EN      = 1,
  localparam int IDX_W       = $clog2(NUM_WEIGHTS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [IDX_W-1:0]        base_idx,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [PIX_W-1:0]        f_in,
  input  logic [PIX_W-1:0]        m_in,
  input  logic [LANES*P_W-1:0]    p_in,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    ovf,
  input  logic [IDX_W-1:0]        rd_addr,
  output logic signed [ACC_W-1:0] rd_data
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] base_q;
  logic             accept;
  logic             base_ok;
  logic             start_ok;
  logic             start_bad;
  logic             clear_fire;

  logic [ACC_W-1:0] bank [NUM_WEIGHTS];
  logic [IDX_W-1:0] lane_idx  [LANES];
  logic [ACC_W-1:0] lane_next [LANES];
  logic [LANES-1:0] lane_valid;
  logic [LANES-1:0] lane_ovf;

  // clear outranks start when both arrive in the same IDLE cycle.
  always_comb begin
    accept     = in_valid && (state_q == RUN);
    base_ok    = int'(base_idx) <= (NUM_WEIGHTS - LANES);
    clear_fire = (state_q == IDLE) && clear;
    start_ok   = (state_q == IDLE) && start && !clear && base_ok;
    start_bad  = (state_q == IDLE) && start && !clear && !base_ok;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value held and infer a latch.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start_ok) state_d = RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        if (accept && in_last) state_d = DRAIN;
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= (state_q == DRAIN);
      err     <= start_bad;
      if (start_ok) base_q <= base_idx;
      if (clear_fire || start_ok) ovf <= 1'b0;
      else if (|lane_ovf)         ovf <= 1'b1;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_idx[g] = base_q + IDX_W'(g);

    proj_lane_mac #(
      .PIX_W  (PIX_W),
      .P_W    (P_W),
      .ACC_W  (ACC_W),
      .SAT_EN (SAT_EN)
    ) u_mac (
      .clk        (clk),
      .rst        (rst),
      .beat       (accept),
      .f          (f_in),
      .m          (m_in),
      .p          (p_in[g*P_W +: P_W]),
      .acc_cur    (bank[lane_idx[g]]),
      .prod_valid (lane_valid[g]),
      .acc_next   (lane_next[g]),
      .acc_ovf    (lane_ovf[g])
    );
  end

  // NOTE: the bank is flops, not RAM: both reset and clear must zero every
  // entry in a single cycle, which a RAM macro cannot do.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WEIGHTS; i++) bank[i] <= '0;
    end else if (clear_fire) begin
      for (int i = 0; i < NUM_WEIGHTS; i++) bank[i] <= '0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (lane_valid[l]) bank[lane_idx[l]] <= lane_next[l];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              rd_data <= '0;
    else if (int'(rd_addr) < NUM_WEIGHTS) rd_data <= bank[rd_addr];
    else                                  rd_data <= '0;
  end

endmodule

// File: tb/tb_proj_accum_bank.sv
// Directed bench: a default 32-bit bank plus 20-bit saturating and wrapping
// banks, all driven by the same stimulus.
module tb_proj_accum_bank;

  logic        clk = 1'b0;
  logic        rst, start, clear, in_valid, in_last;
  logic [7:0]  base_idx, rd_addr;
  logic [8:0]  f_in, m_in;
  logic [63:0] p_in;

  logic               in_ready, busy, done, err, ovf;
  logic signed [31:0] rd_data;
  logic               in_ready_s, busy_s, done_s, err_s, ovf_s;
  logic signed [19:0] rd_data_s;
  logic               in_ready_w, busy_w, done_w, err_w, ovf_w;
  logic signed [19:0] rd_data_w;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  proj_accum_bank u_dut (
    .clk(clk), .rst(rst), .start(start), .base_idx(base_idx), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .f_in(f_in), .m_in(m_in), .p_in(p_in), .busy(busy), .done(done),
    .err(err), .ovf(ovf), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  proj_accum_bank #(.ACC_W(20), .SAT_EN(1)) u_sat (
    .clk(clk), .rst(rst), .start(start), .base_idx(base_idx), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_last(in_last),
    .f_in(f_in), .m_in(m_in), .p_in(p_in), .busy(busy_s), .done(done_s),
    .err(err_s), .ovf(ovf_s), .rd_addr(rd_addr), .rd_data(rd_data_s)
  );

  proj_accum_bank #(.ACC_W(20), .SAT_EN(0)) u_wrap (
    .clk(clk), .rst(rst), .start(start), .base_idx(base_idx), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_w), .in_last(in_last),
    .f_in(f_in), .m_in(m_in), .p_in(p_in), .busy(busy_w), .done(done_w),
    .err(err_w), .ovf(ovf_w), .rd_addr(rd_addr), .rd_data(rd_data_w)
  );

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int addr);
    rd_addr = 8'(addr);
    tick();
  endtask

  task automatic send(input int f, input int m, input int pb, input int ps,
                      input logic last);
    in_valid = 1'b1;
    f_in     = 9'(f);
    m_in     = 9'(m);
    for (int l = 0; l < 8; l++) p_in[l*8 +: 8] = 8'(pb + ps * l);
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    base_idx = '0; rd_addr = '0; f_in = '0; m_in = '0; p_in = '0;

    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ovf", ovf, 0);
    check("rst_rd_data", rd_data, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 240; i++) begin
      rd(i);
      check($sformatf("clr_rd[%0d]", i), rd_data, 0);
    end
    check("clr_ovf", ovf, 0);
    check("clr_busy", busy, 0);

    // Pass 1: base 0, three beats of d=100, p[l]=l+1.
    start = 1'b1; base_idx = 8'd0;
    tick();
    start = 1'b0;
    check("p1_in_ready", in_ready, 1);
    check("p1_busy", busy, 1);
    send(200, 100, 1, 1, 1'b0);
    send(200, 100, 1, 1, 1'b0);
    send(200, 100, 1, 1, 1'b1);
    check("p1_drain_busy", busy, 1);
    check("p1_drain_ready", in_ready, 0);
    check("p1_drain_done", done, 0);
    tick();
    check("p1_done_pulse", done, 1);
    check("p1_idle_busy", busy, 0);
    tick();
    check("p1_done_drop", done, 0);
    rd(0);  check("p1_acc0", rd_data, 300);
    rd(7);  check("p1_acc7", rd_data, 2400);
    rd(8);  check("p1_acc8", rd_data, 0);

    // Pass 2: base 8, single beat f=0 m=511 p=255.
    start = 1'b1; base_idx = 8'd8;
    tick();
    start = 1'b0;
    send(0, 511, 255, 0, 1'b1);
    tick();
    tick();
    rd(8);  check("p2_acc8", rd_data, -130305);
    check("p2_acc8_sat", rd_data_s, -130305);
    rd(15); check("p2_acc15", rd_data, -130305);
    rd(16); check("p2_acc16", rd_data, 0);
    rd(0);  check("p2_acc0", rd_data, 300);
    check("p2_ovf", ovf, 0);

    // Out-of-range base is rejected.
    start = 1'b1; base_idx = 8'd233;
    tick();
    start = 1'b0;
    check("bad_err", err, 1);
    check("bad_busy", busy, 0);
    check("bad_in_ready", in_ready, 0);
    tick();
    check("bad_err_drop", err, 0);
    rd(232); check("bad_acc232", rd_data, 0);

    // Highest legal base; a clear during RUN must be ignored.
    start = 1'b1; base_idx = 8'd232;
    tick();
    start = 1'b0;
    check("hi_err", err, 0);
    check("hi_busy", busy, 1);
    clear = 1'b1;
    send(10, 3, 1, 1, 1'b1);
    clear = 1'b0;
    tick();
    rd(232); check("hi_acc232", rd_data, 7);
    rd(239); check("hi_acc239", rd_data, 56);
    rd(240); check("rd_oob240", rd_data, 0);
    rd(255); check("rd_oob255", rd_data, 0);
    rd(0);   check("hi_acc0_kept", rd_data, 300);

    // clear and start together: clear wins, start dropped.
    clear = 1'b1; start = 1'b1; base_idx = 8'd0;
    tick();
    clear = 1'b0; start = 1'b0;
    check("cs_busy", busy, 0);
    check("cs_in_ready", in_ready, 0);
    rd(0);   check("cs_acc0", rd_data, 0);
    rd(232); check("cs_acc232", rd_data, 0);
    rd(8);   check("cs_acc8", rd_data, 0);

    // Overflow pass: 5 x 130305 exceeds the 20-bit range on the 5th beat.
    start = 1'b1; base_idx = 8'd0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) send(511, 0, 255, 0, k == 4);
    tick();
    check("ov_done", done, 1);
    rd(0);
    check("ov_acc0_32", rd_data, 651525);
    check("ov_acc0_sat", rd_data_s, 524287);
    check("ov_acc0_wrap", rd_data_w, -397051);
    rd(7);
    check("ov_acc7_sat", rd_data_s, 524287);
    check("ov_acc7_wrap", rd_data_w, -397051);
    check("ov_flag_32", ovf, 0);
    check("ov_flag_sat", ovf_s, 1);
    check("ov_flag_wrap", ovf_w, 1);
    tick(); tick(); tick();
    check("ov_sticky_sat", ovf_s, 1);
    check("ov_sticky_wrap", ovf_w, 1);

    // A new accepted start clears ovf; then reset lands mid-pass.
    start = 1'b1; base_idx = 8'd16;
    tick();
    start = 1'b0;
    check("st_ovf_clr_sat", ovf_s, 0);
    in_valid = 1'b1; in_last = 1'b0;
    f_in = 9'd511; m_in = 9'd0; p_in = {8{8'd255}};
    rd_addr = 8'd0;
    tick();
    tick();
    check("mid_busy_pre", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_busy", busy, 0);
    check("mid_in_ready", in_ready, 0);
    check("mid_done", done, 0);
    check("mid_ovf", ovf, 0);
    check("mid_rd_data_sat", rd_data_s, 0);
    tick();
    check("mid_done_hold1", done, 0);
    tick();
    check("mid_done_hold2", done, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    rd(16); check("post_acc16", rd_data, 0);
    rd(0);  check("post_acc0_sat", rd_data_s, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/proj_accum_bank.md
# proj_accum_bank

Parametrised, streaming successor to the eigenface projection accumulator. It consumes one pixel per handshake beat (face value f, mean m, and LANES eigenvector coefficients p). For each lane it accumulates p[l]·(f−m) into accumulator base_idx+l of a NUM_WEIGHTS-deep signed bank. It sits between the pixel/eigenvector fetch logic and the PCIe/Avalon readback path, and adds handshaking, pipelining, saturation, overflow reporting and a random-access readout.

## Interface
- NUM_WEIGHTS, 240: accumulator count.
- LANES, 8: accumulators updated per beat.
- PIX_W, 9: width of f_in/m_in (unsigned).
- P_W, 8: width of each p_in lane (unsigned).
- ACC_W, 32: accumulator width (signed two's complement).
- SAT_EN, 1: 1 = saturate on overflow, 0 = wrap.
- IDX_W = $clog2(NUM_WEIGHTS) (localparam).

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a pass; sampled in IDLE only.
- base_idx  in  IDX_W  first accumulator of the pass; sampled with start.
- clear  in  1  zero bank and ovf; honoured in IDLE only.
- in_valid  in  1  pixel beat valid.
- in_ready  out  1  bank accepts beat.
- in_last  in  1  final beat of pass; qualified by in_valid&&in_ready.
- f_in  in  PIX_W  face pixel.
- m_in  in  PIX_W  mean pixel.
- p_in  in  LANES×P_W  eigen coefficients, lane 0 in LSBs.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse, pass results committed.
- err  out  1  one-cycle pulse, start rejected (bad base_idx).
- ovf  out  1  sticky; any saturation/wrap since last clear/start.
- rd_addr  in  IDX_W  readout address.
- rd_data  out  ACC_W  registered bank[rd_addr].

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE→RUN on start with base_idx ≤ NUM_WEIGHTS−LANES. base_idx is latched and ovf is cleared.
  - start with base_idx > NUM_WEIGHTS−LANES: stay in IDLE, err=1 next cycle, bank untouched.
  - RUN→DRAIN on an accepted beat with in_last=1.
  - DRAIN→IDLE after one cycle, with done=1 in the cycle following the transition.
- in_ready = (state==RUN). A beat is accepted when in_valid && in_ready. The bank never applies backpressure mid-pass.
- Stage 1 (per lane, on accepted beat): d = f_in − m_in as signed PIX_W+1 bits. prod[l] = zero-extended p_in[l] × d, signed PIX_W+P_W+1 bits, registered with a valid bit.
- Stage 2: acc[base+l] ← acc[base+l] + sign-extended prod[l].
  - SAT_EN=1: a result outside [−2^(ACC_W−1), 2^(ACC_W−1)−1] clamps to that bound and sets ovf.
  - SAT_EN=0: the result wraps and sets ovf.
- start does not clear the bank. Passes over the same indices accumulate. clear is the only zeroing path besides reset.
- clear in IDLE zeros all NUM_WEIGHTS accumulators and ovf in one cycle. clear in RUN/DRAIN is ignored. If clear and start occur in the same IDLE cycle, clear wins and start is dropped.
- start in RUN/DRAIN is ignored.
- rd_addr ≥ NUM_WEIGHTS returns 0. Reads are legal in every state and return the current committed value.

## Timing
- Reset values: all accumulators 0, state IDLE; in_ready, busy, done, err, ovf all 0; rd_data 0.
- Cycle sequence:
  - start sampled at edge e0: RUN from e0, in_ready=1 in the following cycle.
  - Beat accepted at edge t: product registered at t, accumulator updated at t+1.
  - Last beat accepted at edge t: DRAIN at t, accumulate and return to IDLE at t+1, done high for the cycle after t+1.
- Throughput: one beat per cycle, latency 2 edges from accepted beat to committed accumulator.
- rd_data latency: 1 cycle after rd_addr. A read of an index updated at edge k returns the new value if rd_addr is presented after k.
- Reset mid-pass: immediate return to IDLE with the bank zeroed. The in-flight product is discarded and done is not pulsed.

## Structure
- Package proj_accum_pkg holds:
  - state enum (IDLE, RUN, DRAIN);
  - function sat_add(acc, prod, sat_en) returning {sum, ovf};
  - default width constants.
- Sub-module proj_lane_mac: one lane's subtract, multiply, pipeline register and sat_add. It is instantiated LANES times via generate. The top holds the FSM, the bank and the readout.

## Test plan
- Reset, then clear; read all indices → every rd_data=0, ovf=0, busy=0.
- start base_idx=0; 3 beats of f=200, m=100, p[l]=l+1, last on beat 3 → acc[l]=300·(l+1), acc[8]=0. done pulses exactly 2 cycles after the last accepted beat.
- f=0, m=511, p=255, single beat, base_idx=8 → acc[8..15]=−130305 (255·−511).
- start base_idx=233 with NUM_WEIGHTS=240, LANES=8 → err pulse, state IDLE, bank unchanged. base_idx=232 → accepted, updates acc[232..239].
- ACC_W=20, SAT_EN=1, repeated f=511, m=0, p=255 beats until the sum would exceed 524287 → acc clamps at 524287, ovf=1 and stays set. Repeat with SAT_EN=0 → value wraps, ovf=1.
- rst asserted mid-pass with in_valid held high → outputs return to reset values immediately. No done pulse. Reads return 0.
